axil_master: RTL and testbench

- Single-outstanding AXI4-Lite master (initiator) that converts a simple command/response handshake into AXI-Lite write and read transactions.
- Drives the accelerator's AXI-Lite register slave for bench and firmware-less bring-up: run/matw at 0x000, control at 0x010.
- One command in flight at a time.
- Write: issues AW and W together; each channel may be accepted in either order.

---
 rtl/axil_master.sv | 190 +++++++++++++++++++
 tb/tb_axil_master.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_master.sv
// Single-outstanding AXI4-Lite initiator that turns a cmd/rsp handshake into AXI-Lite reads and writes.
// Define AXIL_MASTER_TIMEOUT_EN to bound the B/R wait to TIMEOUT_CYCLES, answering 2'b11 / 32'hDEAD_BEEF.
module axil_master #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic [ADDR_W-1:0] M_AXI_AWADDR,
  output logic              M_AXI_AWVALID,
  input  logic              M_AXI_AWREADY,
  output logic [31:0]       M_AXI_WDATA,
  output logic [3:0]        M_AXI_WSTRB,
  output logic              M_AXI_WVALID,
  input  logic              M_AXI_WREADY,
  input  logic [1:0]        M_AXI_BRESP,
  input  logic              M_AXI_BVALID,
  output logic              M_AXI_BREADY,
  output logic [ADDR_W-1:0] M_AXI_ARADDR,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  input  logic [31:0]       M_AXI_RDATA,
  input  logic [1:0]        M_AXI_RRESP,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY
);

  typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP} state_e;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 16-bit wait counter");
  end

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [3:0]          wstrb_q;
  logic                awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic                aw_done_q, w_done_q;
  logic                rsp_valid_q;
  logic [31:0]         rsp_rdata_q;
  logic [1:0]          rsp_resp_q;
  logic                accept;
  logic                timeout_hit;

  assign cmd_ready = (state_q == IDLE) && !rsp_valid_q;
  assign accept    = cmd_valid && cmd_ready;

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_cnt_q;

  // Only the response wait is bounded; address/data VALIDs must never be withdrawn.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else if (accept) begin
      wait_cnt_q <= '0;
    end else if (state_q == WR_RESP || state_q == RD_DATA) begin
      wait_cnt_q <= wait_cnt_q + 16'd1;
    end
  end

  assign timeout_hit = (wait_cnt_q == TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            wstrb_q   <= cmd_wstrb;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            if (cmd_wr) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WR_ADDR_DATA;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= RD_ADDR;
            end
          end
        end
        WR_ADDR_DATA: begin
          // AW and W complete independently; the move to WR_RESP uses the registered flags.
          if (awvalid_q && M_AXI_AWREADY) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (wvalid_q && M_AXI_WREADY) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if (aw_done_q && w_done_q) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bready_q && M_AXI_BVALID) begin
            bready_q    <= 1'b0;
            rsp_resp_q  <= M_AXI_BRESP;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= RSP;
          end else if (timeout_hit) begin
            bready_q    <= 1'b0;
            rsp_resp_q  <= 2'b11;
            rsp_rdata_q <= 32'hDEAD_BEEF;
            rsp_valid_q <= 1'b1;
            state_q     <= RSP;
          end
        end
        RD_ADDR: begin
          if (arvalid_q && M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rready_q && M_AXI_RVALID) begin
            rready_q    <= 1'b0;
            rsp_resp_q  <= M_AXI_RRESP;
            rsp_rdata_q <= M_AXI_RDATA;
            rsp_valid_q <= 1'b1;
            state_q     <= RSP;
          end else if (timeout_hit) begin
            rready_q    <= 1'b0;
            rsp_resp_q  <= 2'b11;
            rsp_rdata_q <= 32'hDEAD_BEEF;
            rsp_valid_q <= 1'b1;
            state_q     <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axil_master.sv
// Bench for axil_master: configurable AXI-Lite slave with a register file, plus a reference register model.
// Build with AXIL_MASTER_TIMEOUT_EN to also exercise the response timeout (TIMEOUT_CYCLES = 8).
module tb_axil_master;
`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata_s;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp_s;

  axil_master #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata_s), .M_AXI_RRESP(rresp_s), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Slave behaviour knobs, changed only between transactions.
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic        r_never = 1'b0, r_force = 1'b0;
  logic [31:0] r_force_val = 32'h0;

  logic        aw_got, w_got, r_pend;
  logic [31:0] aw_addr_s, w_data_s, ar_addr_s;
  logic [3:0]  w_strb_s;
  int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
  int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0;
  logic [31:0] smem [0:15];

  assign awready = awvalid && !aw_got && (aw_wait >= aw_dly);
  assign wready  = wvalid && !w_got && (w_wait >= w_dly);
  assign arready = arvalid && !r_pend && (ar_wait >= ar_dly);
  assign bresp   = bresp_cfg;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0; bvalid <= 1'b0; rvalid <= 1'b0;
      aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0;
      aw_addr_s <= '0; w_data_s <= '0; w_strb_s <= '0; ar_addr_s <= '0;
      rdata_s <= '0; rresp_s <= '0;
      for (int i = 0; i < 16; i++) smem[i] <= '0;
    end else begin
      if (awvalid && awready) begin
        aw_got <= 1'b1; aw_addr_s <= awaddr; aw_wait <= 0; aw_hs <= aw_hs + 1;
      end else if (awvalid && !aw_got) aw_wait <= aw_wait + 1;
      if (wvalid && wready) begin
        w_got <= 1'b1; w_data_s <= wdata; w_strb_s <= wstrb; w_wait <= 0; w_hs <= w_hs + 1;
      end else if (wvalid && !w_got) w_wait <= w_wait + 1;
      if (aw_got && w_got && !bvalid) begin
        if (b_wait >= b_dly) begin
          bvalid <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0; b_wait <= 0;
          for (int i = 0; i < 4; i++)
            if (w_strb_s[i]) smem[aw_addr_s[5:2]][8*i +: 8] <= w_data_s[8*i +: 8];
        end else b_wait <= b_wait + 1;
      end
      if (bvalid && bready) begin
        bvalid <= 1'b0; b_hs <= b_hs + 1;
      end
      if (arvalid && arready) begin
        r_pend <= 1'b1; ar_addr_s <= araddr; ar_wait <= 0; ar_hs <= ar_hs + 1;
      end else if (arvalid && !r_pend) ar_wait <= ar_wait + 1;
      if (r_pend && !rvalid && !r_never) begin
        if (r_wait >= r_dly) begin
          rvalid  <= 1'b1; r_wait <= 0;
          rdata_s <= r_force ? r_force_val : smem[ar_addr_s[5:2]];
          rresp_s <= rresp_cfg;
        end else r_wait <= r_wait + 1;
      end
      if (rvalid && rready) begin
        rvalid <= 1'b0; r_pend <= 1'b0;
      end
    end
  end

  // Protocol watch: a pending VALID must stay high with an unchanged payload until accepted.
  logic        pend_aw, pend_w, pend_ar;
  logic [31:0] aw_prev, w_prev, ar_prev;
  logic [3:0]  ws_prev;
  int          viol_aw = 0, viol_w = 0, viol_ar = 0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_aw <= 1'b0; pend_w <= 1'b0; pend_ar <= 1'b0;
    end else begin
      if (pend_aw && (!awvalid || awaddr != aw_prev)) viol_aw <= viol_aw + 1;
      if (pend_w && (!wvalid || wdata != w_prev || wstrb != ws_prev)) viol_w <= viol_w + 1;
      if (pend_ar && (!arvalid || araddr != ar_prev)) viol_ar <= viol_ar + 1;
      pend_aw <= awvalid && !awready; aw_prev <= awaddr;
      pend_w  <= wvalid && !wready;   w_prev  <= wdata; ws_prev <= wstrb;
      pend_ar <= arvalid && !arready; ar_prev <= araddr;
    end
  end

  int cyc = 0, acc_cnt = 0, last_acc = 0, prev_acc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && cmd_valid && cmd_ready) begin
      acc_cnt <= acc_cnt + 1; last_acc <= cyc; prev_acc <= last_acc;
    end
  end

  // Reference register file: what the command stream says the slave should now hold.
  logic [31:0] rmem [0:15];

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) rmem[i] = '0;
  endtask

  // Issues one command and collects its response; lat counts clock edges from accept to rsp_valid.
  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int hold, output logic [31:0] rd,
                         output logic [1:0] rs, output int lat, output int viol);
    int t;
    int ar0;
    logic [31:0] snap;
    viol = 0; lat = 0; rd = '0; rs = '0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    t = 0;
    while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    while (!rsp_valid && lat < 200) begin
      if (cmd_ready) viol++;
      @(negedge clk); lat++;
    end
    check("rsp_valid_wait", 32'(rsp_valid), 32'd1);
    snap = rsp_rdata; ar0 = ar_hs;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata != snap || cmd_ready || ar_hs != ar0) viol++;
    end
    rd = rsp_rdata; rs = rsp_resp;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (rsp_valid) viol++;
  endtask

  int txn_no = 0;
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] strb, input int hold, output int lat);
    logic [31:0] rd, exp_rd;
    logic [1:0]  rs, exp_rs;
    int viol, a0, w0, b0, r0;
    a0 = aw_hs; w0 = w_hs; b0 = b_hs; r0 = ar_hs;
    exp_rd = wr ? 32'h0 : (r_force ? r_force_val : rmem[addr[5:2]]);
    exp_rs = wr ? bresp_cfg : rresp_cfg;
    run_cmd(wr, addr, data, strb, hold, rd, rs, lat, viol);
    check("rsp_rdata", rd, exp_rd);
    check("rsp_resp", 32'(rs), 32'(exp_rs));
    check("handshake_rules", 32'(viol), 32'd0);
    if (wr) begin
      check("aw_beats", 32'(aw_hs - a0), 32'd1);
      check("w_beats", 32'(w_hs - w0), 32'd1);
      check("b_beats", 32'(b_hs - b0), 32'd1);
      for (int i = 0; i < 4; i++) if (strb[i]) rmem[addr[5:2]][8*i +: 8] = data[8*i +: 8];
    end else begin
      check("ar_beats", 32'(ar_hs - r0), 32'd1);
    end
    $display("[TB] txn %0d %s addr=%h wdata=%h strb=%h -> rdata=%h resp=%0d lat=%0d",
             txn_no, wr ? "WR" : "RD", addr, data, strb, rd, rs, lat);
    txn_no++;
  endtask

  initial begin
    int lat, n0, t;
    logic [31:0] rd, a, d;
    logic [1:0]  rs;
    int viol;
    reset = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valids", {26'd0, awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_resp", 32'(rsp_resp), 32'd0);
    check("rst_addr", awaddr, 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    do_reset();

    // run/matw write then readback; rsp_valid in the 4th cycle counting the accept cycle.
    txn(1'b1, 32'h000, 32'h2, 4'hF, 0, lat);
    check("wr_latency_edges", 32'(lat), 32'd3);
    txn(1'b0, 32'h000, 32'h0, 4'h0, 0, lat);
    txn(1'b1, 32'h010, 32'hA5A5_1234, 4'hF, 0, lat);
    txn(1'b0, 32'h010, 32'h0, 4'h0, 0, lat);

    // W accepted well before AW, then the reverse.
    aw_dly = 3; w_dly = 0;
    txn(1'b1, 32'h008, 32'h1111_2222, 4'hF, 0, lat);
    aw_dly = 0; w_dly = 3;
    txn(1'b1, 32'h00C, 32'h3333_4444, 4'h5, 0, lat);
    w_dly = 0;

    // Error responses pass through unchanged.
    bresp_cfg = 2'b10;
    txn(1'b1, 32'h004, 32'hCAFE_0001, 4'hF, 0, lat);
    bresp_cfg = 2'b00; rresp_cfg = 2'b10; r_force = 1'b1; r_force_val = 32'h55;
    txn(1'b0, 32'h004, 32'h0, 4'h0, 0, lat);
    rresp_cfg = 2'b00; r_force = 1'b0;

    // Consumer back-pressure after a read.
    txn(1'b0, 32'h010, 32'h0, 4'h0, 10, lat);

    // Back-to-back writes with rsp_ready tied high.
    @(negedge clk);
    rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_wr = 1'b1;
    cmd_addr = 32'h020; cmd_wdata = 32'h0BAD_F00D; cmd_wstrb = 4'hF;
    n0 = acc_cnt; t = 0;
    while (acc_cnt < n0 + 3 && t < 100) begin @(negedge clk); t++; end
    cmd_valid = 1'b0;
    check("thru_accepts", 32'(acc_cnt - n0), 32'd3);
    check("thru_period", 32'(last_acc - prev_acc), 32'd5);
    repeat (8) @(negedge clk);
    rsp_ready = 1'b0;
    rmem[8] = 32'h0BAD_F00D;
    txn(1'b0, 32'h020, 32'h0, 4'h0, 0, lat);

    // Randomised traffic against the reference register file.
    for (int k = 0; k < 40; k++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      bresp_cfg = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
      rresp_cfg = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
      a = 32'($urandom_range(0, 15)) << 2;
      d = $urandom;
      txn(1'($urandom_range(0, 1)), a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 2), lat);
    end
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; bresp_cfg = 2'b00; rresp_cfg = 2'b00;

    // Reset while a read address is still waiting for ARREADY.
    ar_dly = 50;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h004;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("arvalid_before_rst", 32'(arvalid), 32'd1);
    #2 reset = 1'b1;
    #1 check("arvalid_in_rst", 32'(arvalid), 32'd0);
    check("rsp_valid_in_rst", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) rmem[i] = '0;
    ar_dly = 0;
    check("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

`ifdef AXIL_MASTER_TIMEOUT_EN
    r_never = 1'b1;
    run_cmd(1'b0, 32'h008, 32'h0, 4'h0, 0, rd, rs, lat, viol);
    check("to_resp", 32'(rs), 32'd3);
    check("to_rdata", rd, 32'hDEAD_BEEF);
    check("to_latency_edges", 32'(lat), 32'(1 + TO));
    check("to_rready_low", 32'(rready), 32'd0);
    r_never = 1'b0;
    do_reset();
`endif

    txn(1'b1, 32'h03C, 32'h1234_5678, 4'hF, 0, lat);
    txn(1'b0, 32'h03C, 32'h0, 4'h0, 0, lat);

    check("aw_stable", 32'(viol_aw), 32'd0);
    check("w_stable", 32'(viol_w), 32'd0);
    check("ar_stable", 32'(viol_ar), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench time limit");
  end
endmodule
